// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and FSM state type for the FIFO read-side word packer
package fifo_pkg;

  localparam int BYTE_W             = 8;
  localparam int DEF_BYTES_PER_WORD = 4;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/fifo_word_packer.sv
// rtl/fifo_word_packer.sv - pops bytes from the byte FIFO and packs them into keep-masked words
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
  parameter int CNT_W          = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [BYTE_W-1:0]                fifo_data,
  input  logic                             fifo_empty,
  output logic                             fifo_rd_en,
  output logic [BYTE_W*BYTES_PER_WORD-1:0] word_out,
  output logic [BYTES_PER_WORD-1:0]        word_keep,
  output logic                             word_valid,
  input  logic                             word_ready,
  input  logic                             flush,
  output logic                             busy,
  output logic [CNT_W-1:0]                 words_sent
);

  localparam int WORD_W = BYTE_W * BYTES_PER_WORD;
  localparam int BC_W   = $clog2(BYTES_PER_WORD + 1);
  localparam logic [BC_W-1:0] LAST_IDX   = BC_W'(BYTES_PER_WORD - 1);
  localparam logic [BC_W:0]   WORD_BYTES = (BC_W + 1)'(BYTES_PER_WORD);

  state_t            r_state;
  state_t            w_state_next;
  logic [BC_W-1:0]   r_byte_cnt;
  logic              r_rd_pend;
  logic              r_flush_req;
  logic [WORD_W-1:0] r_lanes;
  logic [BYTES_PER_WORD-1:0] r_keep;
  logic [CNT_W-1:0]  r_words_sent;

  logic [BC_W:0]     w_inflight;
  logic              w_rd_en;
  logic              w_capture;
  logic              w_last_lane;
  logic              w_handshake;
  logic              w_flush_emit;
  logic              w_flush_empty;

  // Bytes already captured plus the one the FIFO is still returning.
  assign w_inflight    = {1'b0, r_byte_cnt} + {{BC_W{1'b0}}, r_rd_pend};
  assign w_capture     = (r_state == FILL) && r_rd_pend;
  assign w_last_lane   = w_capture && (r_byte_cnt == LAST_IDX);
  assign w_handshake   = (r_state == HOLD) && word_ready;
  // A flush only resolves once no pop is outstanding, so the in-flight byte is included.
  assign w_flush_emit  = (r_state == FILL) && !r_rd_pend && r_flush_req && (r_byte_cnt != '0);
  assign w_flush_empty = (r_state == FILL) && !r_rd_pend && r_flush_req && (r_byte_cnt == '0);

  // Next-state and pop request; pops are only issued while collecting and never past a full word.
  always_comb begin
    w_state_next = r_state;
    w_rd_en      = 1'b0;
    case (r_state)
      FILL: begin
        w_rd_en = !fifo_empty && !r_flush_req && (w_inflight < WORD_BYTES);
        if (w_last_lane || w_flush_emit) begin
          w_state_next = HOLD;
        end
      end
      HOLD: begin
        if (word_ready) begin
          w_state_next = FILL;
        end
      end
      default: w_state_next = FILL;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Lane capture, word release on handshake, flush request tracking and word statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_byte_cnt   <= '0;
      r_rd_pend    <= 1'b0;
      r_flush_req  <= 1'b0;
      r_lanes      <= '0;
      r_keep       <= '0;
      r_words_sent <= '0;
    end else begin
      r_rd_pend <= w_rd_en;
      if (w_capture) begin
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
          if (r_byte_cnt == BC_W'(i)) begin
            r_lanes[i*BYTE_W +: BYTE_W] <= fifo_data;
            r_keep[i]                   <= 1'b1;
          end
        end
        r_byte_cnt <= r_byte_cnt + 1'b1;
      end else if (w_handshake) begin
        r_lanes      <= '0;
        r_keep       <= '0;
        r_byte_cnt   <= '0;
        r_words_sent <= r_words_sent + 1'b1;
      end
      if (w_last_lane || w_flush_emit || w_flush_empty) begin
        r_flush_req <= 1'b0;
      end else if (flush) begin
        r_flush_req <= 1'b1;
      end
    end
  end

  // Reset gates the pop request so no byte leaves the FIFO while state is being cleared.
  assign fifo_rd_en = w_rd_en && !reset;
  assign word_out   = r_lanes;
  assign word_keep  = r_keep;
  assign word_valid = (r_state == HOLD);
  assign busy       = (r_byte_cnt != '0) || r_rd_pend || (r_state == HOLD);
  assign words_sent = r_words_sent;

endmodule

// File: tb/tb_fifo_word_packer.sv
// tb/tb_fifo_word_packer.sv - self-checking bench for fifo_word_packer with a byte-stream model
module tb_fifo_word_packer;

  localparam int BPW = 4;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
  } wexp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  fifo_data = '0;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [31:0] word_out;
  logic [3:0]  word_keep;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic        flush = 1'b0;
  logic        busy;
  logic [15:0] words_sent;

  logic [7:0]  src [0:255];
  int          src_wr = 0;
  int          rd_ptr = 0;

  logic [7:0]  acc_q [$];
  wexp_t       exp_q [$];
  int          m_sent = 0;

  int          n_tests = 0;
  int          n_fail = 0;

  fifo_word_packer #(.BYTES_PER_WORD(BPW), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .word_out   (word_out),
    .word_keep  (word_keep),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .flush      (flush),
    .busy       (busy),
    .words_sent (words_sent)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == src_wr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void emit_word();
    wexp_t w;
    w.data = '0;
    w.keep = '0;
    for (int i = 0; i < acc_q.size(); i++) begin
      w.data[8*i +: 8] = acc_q[i];
      w.keep[i]        = 1'b1;
    end
    exp_q.push_back(w);
    acc_q.delete();
  endfunction

  task automatic push(input logic [7:0] b);
    src[src_wr] = b;
    src_wr++;
  endtask

  task automatic wait_word(input string name, input logic [31:0] d, input logic [3:0] k);
    bit seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (word_valid) seen = 1;
    end
    if (!seen) begin
      chk({name, "_timeout"}, 32'(word_valid), 32'd1);
    end else begin
      chk({name, "_data"}, word_out, d);
      chk({name, "_keep"}, 32'(word_keep), 32'(k));
    end
  endtask

  // FIFO with one-cycle read latency, plus the stream-level packing model.
  initial begin
    logic [7:0] b;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        acc_q.delete();
        exp_q.delete();
        m_sent = 0;
      end else begin
        if (word_valid && word_ready) begin
          if (exp_q.size() > 0) exp_q.delete(0);
          m_sent++;
        end
        if (fifo_rd_en && (rd_ptr != src_wr)) begin
          b = src[rd_ptr];
          fifo_data <= b;
          rd_ptr    <= rd_ptr + 1;
          acc_q.push_back(b);
          if (acc_q.size() == BPW) emit_word();
        end
        if (flush && acc_q.size() > 0) emit_word();
      end
    end
  end

  // Per-cycle comparison of the DUT against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_word_out", word_out, 32'd0);
        chk("rst_valid", 32'(word_valid), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
      end else begin
        chk("busy", 32'(busy), 32'((acc_q.size() > 0) || (exp_q.size() > 0)));
        chk("words_sent", 32'(words_sent), m_sent & 32'hFFFF);
        if (word_valid) begin
          chk("no_pop_in_hold", 32'(fifo_rd_en), 32'd0);
          if (exp_q.size() == 0) begin
            chk("unexpected_word", 32'(word_valid), 32'd0);
          end else begin
            chk("word_out", word_out, exp_q[0].data);
            chk("word_keep", 32'(word_keep), 32'(exp_q[0].keep));
          end
        end
      end
    end
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;

    // Preloaded 0x00..0x07, sink always ready.
    @(negedge clk);
    word_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(8'(i));
    #1 chk("t2_rd_en_c0", 32'(fifo_rd_en), 32'd1);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk);
      #1 chk("t2_rd_en_run", 32'(fifo_rd_en), 32'd1);
    end
    @(posedge clk);
    #1 chk("t2_rd_en_full", 32'(fifo_rd_en), 32'd0);
    wait_word("t2_w0", 32'h03020100, 4'hF);
    wait_word("t2_w1", 32'h07060504, 4'hF);
    repeat (2) @(negedge clk);
    chk("t2_words_sent", 32'(words_sent), 32'd2);

    // Backpressure: word held for 10 cycles, nothing lost.
    word_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    wait_word("t3_w0", 32'h13121110, 4'hF);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_stable", word_out, 32'h13121110);
      chk("t3_rd_en", 32'(fifo_rd_en), 32'd0);
    end
    word_ready = 1'b1;
    @(negedge clk);
    wait_word("t3_w1", 32'h17161514, 4'hF);

    // Partial flush, then an empty flush.
    @(negedge clk);
    push(8'hA1); push(8'hA2); push(8'hA3);
    repeat (6) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_word("t4_partial", 32'h00A3A2A1, 4'b0111);
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    push(8'hB0);
    #1 chk("t4_flush_blocks_pop", 32'(fifo_rd_en), 32'd1 - 32'd1);
    chk("t4_empty_no_word", 32'(word_valid), 32'd0);
    @(posedge clk);
    #1 chk("t4_flush_req_cleared", 32'(fifo_rd_en), 32'd1);

    // FIFO runs dry after two bytes of a word.
    @(negedge clk);
    push(8'hB1);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t5_busy", 32'(busy), 32'd1);
      chk("t5_no_word", 32'(word_valid), 32'd0);
    end
    push(8'hB2); push(8'hB3);
    wait_word("t5_word", 32'hB3B2B1B0, 4'hF);

    // Reset with two bytes captured and a third in flight.
    @(negedge clk);
    for (int i = 0; i < 8; i++) push(8'hC0 + 8'(i));
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t1_word_out", word_out, 32'd0);
    chk("t1_keep", 32'(word_keep), 32'd0);
    chk("t1_valid", 32'(word_valid), 32'd0);
    chk("t1_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_words_sent", 32'(words_sent), 32'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    wait_word("t6_next", 32'hC6C5C4C3, 4'hF);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_word("t6_tail", 32'h000000C7, 4'b0001);
    repeat (3) @(negedge clk);
    chk("t6_words_sent", 32'(words_sent), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
